// File: rtl/sym9_activity_monitor.sv
// Switching-activity and correctness monitor for the 9-input symmetric block.
// Accumulates per-window statistics on accepted samples and emits one report
// record per window over a valid/ready output.
module sym9_activity_monitor #(
  parameter int unsigned WINDOW = 256,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [8:0]       in_vec,
  input  logic             in_result,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_samples,
  output logic [CNT_W-1:0] out_in_toggles,
  output logic [CNT_W-1:0] out_res_toggles,
  output logic [CNT_W-1:0] out_res_ones,
  output logic [CNT_W-1:0] out_mismatch,
  output logic             out_sat
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam int unsigned      SumW   = CNT_W + 4;

  typedef enum logic [0:0] {StAccum, StReport} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] samples_q, in_tog_q, res_tog_q, res_ones_q, mismatch_q;
  logic             sat_q;
  logic [8:0]       prev_vec_q;
  logic             prev_res_q, prev_ok_q;

  logic             accept, golden, go_report;
  logic [3:0]       vec_pop, tog_pop, tog_inc;
  logic             res_tog_inc, ones_inc, mm_inc;
  logic [CNT_W-1:0] samples_d, in_tog_d, res_tog_d, res_ones_d, mismatch_d;
  logic             samples_ov, in_tog_ov, res_tog_ov, res_ones_ov, mismatch_ov;
  logic             sat_d;

  function automatic logic [3:0] popcount9(logic [8:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 9; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

  // Saturating add; MSB of the result flags that the true sum was clipped.
  function automatic logic [CNT_W:0] sat_add(logic [CNT_W-1:0] a, logic [3:0] inc);
    logic [SumW-1:0] sum;
    sum = SumW'(a) + SumW'(inc);
    if (sum > SumW'(CntMax)) begin
      return {1'b1, CntMax};
    end
    return {1'b0, sum[CNT_W-1:0]};
  endfunction

  assign in_ready  = (state_q == StAccum);
  assign out_valid = (state_q == StReport);
  assign accept    = in_valid && in_ready;

  assign vec_pop = popcount9(in_vec);
  assign tog_pop = popcount9(in_vec ^ prev_vec_q);
  assign golden  = (vec_pop >= 4'd3) && (vec_pop <= 4'd6);

  // Post-update counter values for the current cycle and the window-close decision.
  always_comb begin
    tog_inc     = (accept && prev_ok_q) ? tog_pop : 4'd0;
    res_tog_inc = accept && prev_ok_q && (in_result ^ prev_res_q);
    ones_inc    = accept && in_result;
    mm_inc      = accept && (in_result != golden);

    {samples_ov, samples_d}   = sat_add(samples_q, {3'b000, accept});
    {in_tog_ov, in_tog_d}     = sat_add(in_tog_q, tog_inc);
    {res_tog_ov, res_tog_d}   = sat_add(res_tog_q, {3'b000, res_tog_inc});
    {res_ones_ov, res_ones_d} = sat_add(res_ones_q, {3'b000, ones_inc});
    {mismatch_ov, mismatch_d} = sat_add(mismatch_q, {3'b000, mm_inc});

    sat_d = sat_q | samples_ov | in_tog_ov | res_tog_ov | res_ones_ov | mismatch_ov;

    // An empty-window flush is dropped; flush in REPORT never gets here.
    go_report = in_ready &&
                ((accept && (samples_d == CNT_W'(WINDOW))) || (flush && (samples_d != '0)));
  end

  // State, counters, toggle history and report snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StAccum;
      samples_q       <= '0;
      in_tog_q        <= '0;
      res_tog_q       <= '0;
      res_ones_q      <= '0;
      mismatch_q      <= '0;
      sat_q           <= 1'b0;
      prev_vec_q      <= '0;
      prev_res_q      <= 1'b0;
      prev_ok_q       <= 1'b0;
      out_samples     <= '0;
      out_in_toggles  <= '0;
      out_res_toggles <= '0;
      out_res_ones    <= '0;
      out_mismatch    <= '0;
      out_sat         <= 1'b0;
    end else begin
      // History spans windows so activity is measured continuously.
      if (accept) begin
        prev_vec_q <= in_vec;
        prev_res_q <= in_result;
        prev_ok_q  <= 1'b1;
      end
      unique case (state_q)
        StAccum: begin
          if (go_report) begin
            state_q         <= StReport;
            out_samples     <= samples_d;
            out_in_toggles  <= in_tog_d;
            out_res_toggles <= res_tog_d;
            out_res_ones    <= res_ones_d;
            out_mismatch    <= mismatch_d;
            out_sat         <= sat_d;
            samples_q       <= '0;
            in_tog_q        <= '0;
            res_tog_q       <= '0;
            res_ones_q      <= '0;
            mismatch_q      <= '0;
            sat_q           <= 1'b0;
          end else begin
            samples_q  <= samples_d;
            in_tog_q   <= in_tog_d;
            res_tog_q  <= res_tog_d;
            res_ones_q <= res_ones_d;
            mismatch_q <= mismatch_d;
            sat_q      <= sat_d;
          end
        end
        StReport: begin
          if (out_ready) begin
            state_q <= StAccum;
          end
        end
        default: state_q <= StAccum;
      endcase
    end
  end

endmodule

// File: tb/tb_sym9_activity_monitor.sv
// Bench for sym9_activity_monitor: three instances (WINDOW=4, default, and
// CNT_W=4/WINDOW=8) against a per-window arithmetic reference model.
module tb_sym9_activity_monitor;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       vld [3];
  logic       fl  [3];
  logic       res [3];
  logic       ordy[3];
  logic [8:0] vec [3];

  logic        rdy [3];
  logic        ov  [3];
  logic        osat[3];
  logic [15:0] o_smp[3], o_tin[3], o_trs[3], o_one[3], o_mm[3];

  logic        a_rdy, a_ov, a_sat, b_rdy, b_ov, b_sat, c_rdy, c_ov, c_sat;
  logic [15:0] a_smp, a_tin, a_trs, a_one, a_mm;
  logic [15:0] b_smp, b_tin, b_trs, b_one, b_mm;
  logic [3:0]  c_smp, c_tin, c_trs, c_one, c_mm;

  sym9_activity_monitor #(.WINDOW(4), .CNT_W(16)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(vld[0]), .in_ready(a_rdy), .in_vec(vec[0]),
    .in_result(res[0]), .flush(fl[0]), .out_valid(a_ov), .out_ready(ordy[0]),
    .out_samples(a_smp), .out_in_toggles(a_tin), .out_res_toggles(a_trs),
    .out_res_ones(a_one), .out_mismatch(a_mm), .out_sat(a_sat)
  );

  sym9_activity_monitor u_def (
    .clk(clk), .rst(rst), .in_valid(vld[1]), .in_ready(b_rdy), .in_vec(vec[1]),
    .in_result(res[1]), .flush(fl[1]), .out_valid(b_ov), .out_ready(ordy[1]),
    .out_samples(b_smp), .out_in_toggles(b_tin), .out_res_toggles(b_trs),
    .out_res_ones(b_one), .out_mismatch(b_mm), .out_sat(b_sat)
  );

  sym9_activity_monitor #(.WINDOW(8), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .in_valid(vld[2]), .in_ready(c_rdy), .in_vec(vec[2]),
    .in_result(res[2]), .flush(fl[2]), .out_valid(c_ov), .out_ready(ordy[2]),
    .out_samples(c_smp), .out_in_toggles(c_tin), .out_res_toggles(c_trs),
    .out_res_ones(c_one), .out_mismatch(c_mm), .out_sat(c_sat)
  );

  always_comb begin
    rdy[0] = a_rdy; rdy[1] = b_rdy; rdy[2] = c_rdy;
    ov[0] = a_ov; ov[1] = b_ov; ov[2] = c_ov;
    osat[0] = a_sat; osat[1] = b_sat; osat[2] = c_sat;
    o_smp[0] = a_smp; o_smp[1] = b_smp; o_smp[2] = 16'(c_smp);
    o_tin[0] = a_tin; o_tin[1] = b_tin; o_tin[2] = 16'(c_tin);
    o_trs[0] = a_trs; o_trs[1] = b_trs; o_trs[2] = 16'(c_trs);
    o_one[0] = a_one; o_one[1] = b_one; o_one[2] = 16'(c_one);
    o_mm[0] = a_mm; o_mm[1] = b_mm; o_mm[2] = 16'(c_mm);
  end

  int checks = 0;
  int failures = 0;

  // Reference model: true (unclipped) window totals, clipped only at report time.
  int unsigned win [3] = '{4, 256, 8};
  int unsigned maxv[3] = '{65535, 65535, 15};
  int          cnt[3], tin[3], tres[3], ones[3], mm[3];
  logic [8:0]  lastv[3];
  logic        lastr[3], hasl[3], pending[3];
  int          e_smp[3], e_tin[3], e_trs[3], e_one[3], e_mm[3];
  logic        e_sat[3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic golden(input logic [8:0] v);
    int c;
    c = $countones(v);
    return (c >= 3) && (c <= 6);
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 3; d++) begin
      cnt[d] = 0; tin[d] = 0; tres[d] = 0; ones[d] = 0; mm[d] = 0;
      lastv[d] = '0; lastr[d] = 1'b0; hasl[d] = 1'b0; pending[d] = 1'b0;
    end
  endfunction

  function automatic int clip(input int d, input int x);
    return (x > int'(maxv[d])) ? int'(maxv[d]) : x;
  endfunction

  function automatic void model_accept(input int d, input logic [8:0] v, input logic r);
    if (hasl[d]) begin
      tin[d]  += $countones(v ^ lastv[d]);
      tres[d] += int'(r ^ lastr[d]);
    end
    hasl[d] = 1'b1; lastv[d] = v; lastr[d] = r;
    cnt[d]++;
    ones[d] += int'(r);
    mm[d]   += int'(r != golden(v));
  endfunction

  function automatic void model_close(input int d);
    e_smp[d] = clip(d, cnt[d]);
    e_tin[d] = clip(d, tin[d]);
    e_trs[d] = clip(d, tres[d]);
    e_one[d] = clip(d, ones[d]);
    e_mm[d]  = clip(d, mm[d]);
    e_sat[d] = (cnt[d] > int'(maxv[d])) || (tin[d] > int'(maxv[d])) ||
               (tres[d] > int'(maxv[d])) || (ones[d] > int'(maxv[d])) ||
               (mm[d] > int'(maxv[d]));
    pending[d] = 1'b1;
    cnt[d] = 0; tin[d] = 0; tres[d] = 0; ones[d] = 0; mm[d] = 0;
  endfunction

  task automatic send(input int d, input logic [8:0] v, input logic r, input logic f);
    int n_wait = 0;
    vld[d] = 1'b1; vec[d] = v; res[d] = r; fl[d] = f;
    while (rdy[d] !== 1'b1 && n_wait < 64) begin
      tick();
      n_wait++;
    end
    chk("accept_wait", 32'(rdy[d]), 1);
    tick();
    vld[d] = 1'b0; fl[d] = 1'b0;
    model_accept(d, v, r);
    if (cnt[d] == int'(win[d]) || f) begin
      model_close(d);
      chk("report_latency", 32'(ov[d]), 1);
    end
  endtask

  task automatic flush_only(input int d);
    fl[d] = 1'b1;
    tick();
    fl[d] = 1'b0;
    if (cnt[d] > 0) begin
      model_close(d);
      chk("flush_latency", 32'(ov[d]), 1);
    end else begin
      chk("empty_flush_valid", 32'(ov[d]), 0);
    end
  endtask

  task automatic check_fields(input int d, input string tag);
    chk({tag, "_samples"}, 32'(o_smp[d]), e_smp[d]);
    chk({tag, "_in_toggles"}, 32'(o_tin[d]), e_tin[d]);
    chk({tag, "_res_toggles"}, 32'(o_trs[d]), e_trs[d]);
    chk({tag, "_res_ones"}, 32'(o_one[d]), e_one[d]);
    chk({tag, "_mismatch"}, 32'(o_mm[d]), e_mm[d]);
    chk({tag, "_sat"}, 32'(osat[d]), 32'(e_sat[d]));
  endtask

  task automatic check_report(input int d, input int hold);
    int w = 0;
    while (ov[d] !== 1'b1 && w < 64) begin
      tick();
      w++;
    end
    chk("report_valid", 32'(ov[d]), 1);
    check_fields(d, "report");
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", 32'(ov[d]), 1);
      chk("hold_in_ready", 32'(rdy[d]), 0);
      chk("hold_in_toggles", 32'(o_tin[d]), e_tin[d]);
      chk("hold_samples", 32'(o_smp[d]), e_smp[d]);
    end
    ordy[d] = 1'b1;
    tick();
    ordy[d] = 1'b0;
    pending[d] = 1'b0;
    chk("post_in_ready", 32'(rdy[d]), 1);
    chk("post_valid", 32'(ov[d]), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  logic [8:0] s1_vec[4] = '{9'h000, 9'h1FF, 9'h007, 9'h07F};

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      vld[d] = 1'b0; fl[d] = 1'b0; res[d] = 1'b0; ordy[d] = 1'b0; vec[d] = '0;
    end
    rst = 1'b1;
    tick();
    do_reset();

    // Reset state of every instance.
    for (int d = 0; d < 3; d++) begin
      chk("reset_valid", 32'(ov[d]), 0);
      chk("reset_in_ready", 32'(rdy[d]), 1);
      chk("reset_samples", 32'(o_smp[d]), 0);
      chk("reset_sat", 32'(osat[d]), 0);
    end

    // Window of four with golden results: 19 input toggles, 2 result toggles.
    for (int i = 0; i < 4; i++) send(0, s1_vec[i], golden(s1_vec[i]), 1'b0);
    chk("s1_in_toggles_const", 32'(o_tin[0]), 19);
    check_report(0, 0);

    // Result forced high from a fresh reset.
    do_reset();
    for (int i = 0; i < 4; i++) send(0, s1_vec[i], 1'b1, 1'b0);
    chk("s2_mismatch_const", 32'(o_mm[0]), 3);
    check_report(0, 0);

    // Backpressure in REPORT with a sample waiting at the input.
    for (int i = 0; i < 4; i++) send(0, s1_vec[i], golden(s1_vec[i]), 1'b0);
    vld[0] = 1'b1; vec[0] = 9'h0F0; res[0] = 1'b1;
    check_report(0, 10);
    tick();
    vld[0] = 1'b0;
    model_accept(0, 9'h0F0, 1'b1);
    for (int i = 0; i < 3; i++) send(0, s1_vec[i], golden(s1_vec[i]), 1'b0);
    check_report(0, 1);

    // Flush together with the third sample, then an empty-window flush.
    send(1, 9'h011, 1'b0, 1'b0);
    send(1, 9'h0E1, 1'b1, 1'b0);
    send(1, 9'h1C3, 1'b1, 1'b1);
    chk("flush_samples_const", 32'(o_smp[1]), 3);
    check_report(1, 2);
    flush_only(1);
    tick();
    chk("empty_flush_still_idle", 32'(ov[1]), 0);

    // Saturation with CNT_W=4, then a clean window.
    for (int i = 0; i < 8; i++) send(2, (i % 2 == 0) ? 9'h000 : 9'h1FF, 1'b0, 1'b0);
    chk("sat_in_toggles_const", 32'(o_tin[2]), 15);
    chk("sat_flag_const", 32'(osat[2]), 1);
    check_report(2, 0);
    for (int i = 0; i < 8; i++) send(2, 9'h000, 1'b0, 1'b0);
    check_report(2, 0);

    // Reset while a report is pending.
    for (int i = 0; i < 4; i++) send(0, s1_vec[i], 1'b0, 1'b0);
    chk("pre_reset_valid", 32'(ov[0]), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    chk("rst_report_valid", 32'(ov[0]), 0);
    chk("rst_report_samples", 32'(o_smp[0]), 0);
    chk("rst_report_in_ready", 32'(rdy[0]), 1);
    for (int i = 0; i < 4; i++) send(0, 9'h1FF, 1'b0, 1'b0);
    chk("rst_first_toggles_const", 32'(o_tin[0]), 0);
    check_report(0, 0);

    // Randomized traffic on the WINDOW=4 instance.
    for (int it = 0; it < 300; it++) begin
      logic [8:0] v;
      logic       r;
      logic       f;
      v = 9'($urandom_range(0, 511));
      r = ($urandom_range(0, 3) == 0) ? 1'($urandom_range(0, 1)) : golden(v);
      f = ($urandom_range(0, 11) == 0);
      send(0, v, r, f);
      if (pending[0]) check_report(0, $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) tick();
      if ($urandom_range(0, 19) == 0) begin
        flush_only(0);
        if (pending[0]) check_report(0, 0);
      end
    end
    flush_only(0);
    if (pending[0]) check_report(0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
